// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN expression controller: stack commands, opcodes, FSM states.
// Optional multiply support is enabled by defining RPN_MUL_EN.
package rpn_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_CLEAR = 2'b01,
    CMD_PUSH  = 2'b10,
    CMD_POP   = 2'b11
  } stk_cmd_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_EQ  = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PUSH, S_POP_B, S_WAIT_B, S_POP_A,
    S_WAIT_A, S_PUSH_R, S_POP_R, S_WAIT_R, S_CLR, S_ERR
  } state_t;

  // Opcodes that pop two operands and push one result.
  function automatic logic is_binop(input logic [2:0] op);
    is_binop = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND)
`ifdef RPN_MUL_EN
               || (op == OP_MUL)
`endif
               ;
  endfunction

endpackage

// File: rtl/rpn_if.sv
// Token, stack-command and result signals of the RPN controller bundled in one interface.
// Handshake: a token transfers on a rising edge where tok_valid && tok_ready; tok_* must stay stable while tok_valid waits.
interface rpn_if #(parameter int W = 8);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic [W-1:0] tok_data;
  logic [1:0]   stk_cmd;
  logic [W-1:0] stk_data_in;
  logic [W-1:0] stk_data_out;
  logic         stk_full;
  logic         stk_empty;
  logic         stk_error;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         err;

  modport master (
    input  tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty, stk_error,
    output tok_ready, stk_cmd, stk_data_in, res_valid, res_data, err
  );

  modport slave (
    output tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty, stk_error,
    input  tok_ready, stk_cmd, stk_data_in, res_valid, res_data, err
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational W-bit datapath for the binary RPN operators; a is the deeper operand, b the former top.
// The MUL path exists only when RPN_MUL_EN is defined.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
`ifdef RPN_MUL_EN
      OP_MUL:  r = a * b;
`endif
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN expression controller: turns operand/operator tokens into stack command sequences.
// Define RPN_MUL_EN to accept opcode 101 as multiply.
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  rpn_if.master  bus,
  output state_t dbg_state
);

  state_t       state;
  logic [2:0]   op_q;
  logic [W-1:0] b_q;
  logic [W-1:0] alu_r;
  logic         accept;

  assign bus.tok_ready = (state == S_IDLE);
  assign accept        = bus.tok_valid && bus.tok_ready;
  assign dbg_state     = state;

  // a comes straight from the stack output during WAIT_A, when it holds the second pop.
  rpn_alu #(.W(W)) u_alu (
    .a  (bus.stk_data_out),
    .b  (b_q),
    .op (op_q),
    .r  (alu_r)
  );

  // INIT is gated by rst_n so no clear is issued while reset is still held.
  always_comb begin
    bus.stk_cmd = CMD_NOP;
    case (state)
      S_INIT:                    bus.stk_cmd = rst_n ? CMD_CLEAR : CMD_NOP;
      S_PUSH:                    if (!bus.stk_full) bus.stk_cmd = CMD_PUSH;
      S_PUSH_R:                  bus.stk_cmd = CMD_PUSH;
      S_POP_B, S_POP_A, S_POP_R: if (!bus.stk_empty) bus.stk_cmd = CMD_POP;
      S_CLR, S_ERR:              bus.stk_cmd = CMD_CLEAR;
      default:                   bus.stk_cmd = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_INIT;
      op_q            <= '0;
      b_q             <= '0;
      bus.stk_data_in <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.err         <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (accept) begin
            if (!bus.tok_is_op) begin
              bus.stk_data_in <= bus.tok_data;
              state           <= S_PUSH;
            end else begin
              op_q <= bus.tok_data[2:0];
              if (is_binop(bus.tok_data[2:0]))     state <= S_POP_B;
              else if (bus.tok_data[2:0] == OP_EQ)  state <= S_POP_R;
              else if (bus.tok_data[2:0] == OP_CLR) state <= S_CLR;
              else                                  state <= S_ERR;
            end
          end
        end
        S_PUSH:   state <= bus.stk_full ? S_ERR : S_IDLE;
        S_POP_B:  state <= bus.stk_empty ? S_ERR : S_WAIT_B;
        S_WAIT_B: begin
          b_q   <= bus.stk_data_out;
          state <= S_POP_A;
        end
        S_POP_A:  state <= bus.stk_empty ? S_ERR : S_WAIT_A;
        S_WAIT_A: begin
          bus.stk_data_in <= alu_r;
          state           <= S_PUSH_R;
        end
        S_PUSH_R: state <= S_IDLE;
        S_POP_R:  state <= bus.stk_empty ? S_ERR : S_WAIT_R;
        S_WAIT_R: begin
          bus.res_data  <= bus.stk_data_out;
          bus.res_valid <= 1'b1;
          state         <= S_IDLE;
        end
        S_CLR: begin
          bus.err <= 1'b0;
          state   <= S_IDLE;
        end
        S_ERR: begin
          bus.err <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
      // A stack fault anywhere in a command sequence aborts it.
      if (state != S_IDLE && bus.stk_error) state <= S_ERR;
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Directed bench for rpn_ctrl with a behavioural 4-deep stack on its command port.
// Covers reset, arithmetic, error paths, overflow, mid-sequence reset and the RPN_MUL_EN opcode.
module tb_rpn_ctrl;
  import rpn_pkg::*;

  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   stk_rst_n = 1'b0;
  state_t dbg_state;

  int checks = 0;
  int passes = 0;
  int n_push = 0;
  int n_pop = 0;
  int n_clear = 0;
  int n_res = 0;
  logic [7:0] exp_q[$];

  rpn_if #(.W(8)) bus ();

  rpn_ctrl #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stack model ----------------
  logic [7:0] mem [DEPTH];
  int         sp;
  logic [7:0] s_dout;
  logic       s_err;

  always @(posedge clk or negedge stk_rst_n) begin
    if (!stk_rst_n) begin
      sp     <= 0;
      s_dout <= '0;
      s_err  <= 1'b0;
    end else begin
      s_err <= 1'b0;
      case (bus.stk_cmd)
        2'b01: sp <= 0;
        2'b10: if (sp == DEPTH) s_err <= 1'b1;
               else begin mem[sp] <= bus.stk_data_in; sp <= sp + 1; end
        2'b11: if (sp == 0) s_err <= 1'b1;
               else begin s_dout <= mem[sp-1]; sp <= sp - 1; end
        default: ;
      endcase
    end
  end

  assign bus.stk_data_out = s_dout;
  assign bus.stk_full     = (sp == DEPTH);
  assign bus.stk_empty    = (sp == 0);
  assign bus.stk_error    = s_err;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.stk_cmd == 2'b10) n_push  <= n_push + 1;
      if (bus.stk_cmd == 2'b11) n_pop   <= n_pop + 1;
      if (bus.stk_cmd == 2'b01) n_clear <= n_clear + 1;
    end
  end

  // ---------------- check / scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid) begin
      n_res++;
      if (exp_q.size() == 0) check("res_unexpected", 32'd1, 32'd0);
      else check("res_data", {24'd0, bus.res_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tok(input logic is_op, input logic [7:0] d);
    int n;
    n = 0;
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_data  = d;
    while (!bus.tok_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.tok_valid = 1'b0;
  endtask

  // Counts busy cycles after acceptance until tok_ready returns.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.tok_ready && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 64) check("ready_timeout", 32'd0, 32'd1);
    #2;
  endtask

  task automatic run_expr(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
    int cyc;
    int r0, p0, q0;
    r0 = n_res; p0 = n_pop; q0 = n_push;
    send_tok(1'b0, a);  wait_ready(cyc); check({tag, "_lat_opnd"}, cyc, 1);
    send_tok(1'b0, b);  wait_ready(cyc);
    send_tok(1'b1, op); wait_ready(cyc); check({tag, "_lat_binop"}, cyc, 5);
    check({tag, "_depth"}, sp, 1);
    exp_q.push_back(exp);
    send_tok(1'b1, {5'd0, OP_EQ}); wait_ready(cyc); check({tag, "_lat_eq"}, cyc, 2);
    check({tag, "_res_valid"}, bus.res_valid, 1);
    check({tag, "_res_count"}, n_res - r0, 1);
    check({tag, "_exp_drained"}, exp_q.size(), 0);
    check({tag, "_pops"}, n_pop - p0, 3);
    check({tag, "_pushes"}, n_push - q0, 3);
    check({tag, "_empty"}, sp, 0);
    @(negedge clk); #2;
    check({tag, "_res_pulse"}, bus.res_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int c0, p0, q0, r0;
    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, S_INIT);
    check("rst_tok_ready", bus.tok_ready, 0);
    check("rst_stk_cmd", bus.stk_cmd, 0);
    check("rst_data_in", bus.stk_data_in, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_err", bus.err, 0);
    stk_rst_n = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("init_clear", bus.stk_cmd, 1);
    check("init_not_ready", bus.tok_ready, 0);
    @(negedge clk); #2;
    check("idle_ready", bus.tok_ready, 1);
    check("idle_cmd", bus.stk_cmd, 0);
    check("idle_err", bus.err, 0);

    run_expr("add", 8'h03, 8'h04, {5'd0, OP_ADD}, 8'h07);
    run_expr("sub", 8'h02, 8'h05, {5'd0, OP_SUB}, 8'hFD);
    run_expr("and", 8'h0F, 8'h3C, {5'd0, OP_AND}, 8'h0C);

    // second pop of ADD finds the stack empty
    c0 = n_clear;
    send_tok(1'b0, 8'h09);         wait_ready(cyc);
    send_tok(1'b1, {5'd0, OP_ADD}); wait_ready(cyc);
    check("under_lat", cyc, 4);
    check("under_err", bus.err, 1);
    check("under_clear", n_clear - c0, 1);
    check("under_empty", sp, 0);
    send_tok(1'b1, {5'd0, OP_CLR}); wait_ready(cyc);
    check("clr_lat", cyc, 1);
    check("clr_err", bus.err, 0);
    r0 = n_res;
    send_tok(1'b1, {5'd0, OP_EQ}); wait_ready(cyc);
    check("eq_empty_lat", cyc, 2);
    check("eq_empty_err", bus.err, 1);
    check("eq_empty_nores", n_res - r0, 0);
    send_tok(1'b1, {5'd0, OP_CLR}); wait_ready(cyc);

    // fill to full, then one more operand
    q0 = n_push;
    for (int i = 0; i < DEPTH; i++) begin
      send_tok(1'b0, 8'h20 + 8'(i)); wait_ready(cyc);
    end
    check("fill_full", bus.stk_full, 1);
    check("fill_err", bus.err, 0);
    send_tok(1'b0, 8'h55); wait_ready(cyc);
    check("over_lat", cyc, 2);
    check("over_pushes", n_push - q0, DEPTH);
    check("over_err", bus.err, 1);
    check("over_cleared", sp, 0);
    send_tok(1'b1, {5'd0, OP_CLR}); wait_ready(cyc);

    // illegal opcode, upper token bits ignored
    send_tok(1'b1, 8'hF6); wait_ready(cyc);
    check("illegal_lat", cyc, 1);
    check("illegal_err", bus.err, 1);
    send_tok(1'b1, {5'd0, OP_CLR}); wait_ready(cyc);
    check("illegal_clr", bus.err, 0);

`ifdef RPN_MUL_EN
    run_expr("mul", 8'h10, 8'h11, {5'd0, OP_MUL}, 8'h10);
`else
    p0 = n_pop;
    send_tok(1'b0, 8'h10); wait_ready(cyc);
    send_tok(1'b0, 8'h11); wait_ready(cyc);
    send_tok(1'b1, {5'd0, OP_MUL}); wait_ready(cyc);
    check("mul_off_lat", cyc, 1);
    check("mul_off_err", bus.err, 1);
    check("mul_off_nopop", n_pop - p0, 0);
    check("mul_off_cleared", sp, 0);
    send_tok(1'b1, {5'd0, OP_CLR}); wait_ready(cyc);
`endif

    // reset while an ADD is about to pop
    send_tok(1'b0, 8'h01); wait_ready(cyc);
    send_tok(1'b0, 8'h02); wait_ready(cyc);
    send_tok(1'b1, {5'd0, OP_ADD});
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", bus.stk_cmd, 0);
    check("midrst_state", dbg_state, S_INIT);
    p0 = n_pop;
    repeat (2) @(negedge clk);
    check("midrst_nopop", n_pop - p0, 0);
    check("midrst_depth", sp, 2);
    rst_n = 1'b1;
    #1;
    check("midrst_clear", bus.stk_cmd, 1);
    @(negedge clk); #2;
    check("midrst_cleared", sp, 0);
    check("midrst_ready", bus.tok_ready, 1);

    run_expr("wrap", 8'h80, 8'h80, {5'd0, OP_ADD}, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
